rv32_mod_muldiv_seq: RTL

Iterative sequencer for RV32M multiply/divide, sitting beside the single-cycle ALU in the execute stage.
Accepts one M-extension operation through a valid/ready request port and runs a radix-2 shift/add or restoring-subtract datapath for 32 iterations.
Returns the result with its destination tag on a valid/ready response port.
While occupied it drives busy, which the execute stage uses to stall the pipeline.

---
 rtl/rv32_mod_muldiv_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rv32_mod_muldiv_seq.sv
// rv32_mod_muldiv_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift/add multiply, restoring divide, one-cycle sign fixup.
module rv32_mod_muldiv_seq #(
  parameter int FAST_SPECIAL = 1,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIX, S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dz_q, dz_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;

  logic        sgn_a, sgn_b;
  logic        in_neg_a, in_neg_b;
  logic        in_dz, in_ovf, early;
  logic [31:0] in_a, in_b, spec_res;

  assign sgn_a = (req_op == OP_MULH)
              || (req_op == OP_MULHSU)
              || (req_op == OP_DIV)
              || (req_op == OP_REM);
  assign sgn_b = (req_op == OP_MULH)
              || (req_op == OP_DIV)
              || (req_op == OP_REM);

  assign in_neg_a = sgn_a & req_rs1[31];
  assign in_neg_b = sgn_b & req_rs2[31];
  assign in_a = in_neg_a ? -req_rs1 : req_rs1;
  assign in_b = in_neg_b ? -req_rs2 : req_rs2;

  assign in_dz  = (req_rs2 == 32'd0);
  assign in_ovf = ((req_op == OP_DIV) || (req_op == OP_REM))
               && (req_rs1 == 32'h8000_0000)
               && (req_rs2 == 32'hFFFF_FFFF);
  assign early  = (FAST_SPECIAL != 0) && req_op[2]
               && (in_dz || in_ovf);

  // req_op[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_res = in_dz
    ? (req_op[1] ? req_rs1 : 32'hFFFF_FFFF)
    : (req_op[1] ? 32'd0 : 32'h8000_0000);

  logic [32:0] mul_sum, rem_sh;
  logic        div_ge;
  logic [31:0] div_rem;

  assign mul_sum = {1'b0, acc_q[63:32]}
                 + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign rem_sh  = {acc_q[63:32], acc_q[31]};
  assign div_ge  = rem_sh >= {1'b0, b_q};
  assign div_rem = div_ge ? (rem_sh[31:0] - b_q)
                          : rem_sh[31:0];

  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo  = dz_q ? 32'hFFFF_FFFF
              : ((neg_a_q ^ neg_b_q) ? -acc_q[31:0]
                                     : acc_q[31:0]);
  assign rem  = neg_a_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d    = req_op;
            tag_d   = req_tag;
            a_d     = in_a;
            b_d     = in_b;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            dz_d    = in_dz;
            cnt_d   = 5'd31;
            acc_d   = req_op[2] ? {32'd0, in_a}
                                : {32'd0, in_b};
            if (early) begin
              res_d   = spec_res;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = op_q[2]
            ? {div_rem, acc_q[30:0], div_ge}
            : {mul_sum, acc_q[31:1]};
          if (cnt_q == 5'd0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_FIX: begin
          unique case (op_q)
            OP_MUL:    res_d = prod[31:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  res_d = prod[63:32];
            OP_DIV,
            OP_DIVU:   res_d = quo;
            default:   res_d = rem;
          endcase
          state_d = S_DONE;
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = res_q;
  assign resp_tag   = tag_q;

endmodule
